goertzel_seq: RTL
=================

GOERTZEL_SEQ -- requirements
Module: goertzel_seq

Interface
REQ-001 Parameter N, default 205, Goertzel frame length in samples (N >= 2).
REQ-002 Parameter SW, default 8, sample width matching the ADC sample bus.
REQ-003 Local CW = $clog2(N), sample counter width.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 nrst  input  1  synchronous, active-low reset.
REQ-006 start  input  1  one-cycle request to acquire and process one frame.
REQ-007 abort  input  1  cancel current frame.
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 adc_ready  output  1  ready to the ADC; a sample transfers when adc_valid and adc_ready are both high.
REQ-010 adc_valid  input  1  ADC sample valid.
REQ-011 adc_sample  input  SW  ADC sample.
REQ-012 core_clr  output  1  one-cycle clear of Goertzel core state (s1, s2).
REQ-013 core_en  output  1  core_sample is valid; core performs one iteration.
REQ-014 core_sample  output  SW  registered sample to core.
REQ-015 core_last  output  1  high with core_en on the N-th sample of the frame.
REQ-016 core_done  input  1  core has finished computing the magnitude for the frame.
REQ-017 frame_done  output  1  one-cycle pulse when a frame completes.
REQ-018 sample_cnt  output  CW  samples accepted in the current frame.

Function
REQ-019 FSM states IDLE, CLEAR, ACQ, WAIT_CORE, DONE.
REQ-020 IDLE: adc_ready=0; start=1 -> CLEAR next cycle; otherwise stay.
REQ-021 CLEAR: core_clr=1 for exactly one cycle, sample_cnt <= 0, -> ACQ.
REQ-022 ACQ: adc_ready=1 (registered, so it rises the cycle after CLEAR).
REQ-023 In ACQ, each transfer registers adc_sample into core_sample and asserts core_en in the next cycle; latency exactly 1 cycle.
REQ-024 core_en is never asserted without a transfer in the preceding cycle; gaps in adc_valid produce gaps in core_en.
REQ-025 sample_cnt increments by 1 per transfer and never exceeds N-1 (no wrap within a frame).
REQ-026 The transfer with sample_cnt == N-1 sets core_last=1 alongside its core_en, drops adc_ready the next cycle, and moves to WAIT_CORE.
REQ-027 Exactly N transfers occur per frame; adc_valid after the N-th transfer is not accepted.
REQ-028 WAIT_CORE: adc_ready=0; core_done=1 -> DONE.
REQ-029 DONE: frame_done=1 for one cycle, -> IDLE.
REQ-030 start while busy is ignored (no restart, no queuing).
REQ-031 core_done outside WAIT_CORE is ignored.
REQ-032 abort in any non-IDLE state -> IDLE next cycle: adc_ready=0, core_en=0, no frame_done; an in-flight core_en from the abort cycle's transfer is suppressed.
REQ-033 start and abort in the same IDLE cycle: abort wins, stay IDLE.
REQ-034 core_done in the same cycle as abort: abort wins, no frame_done.

Reset
REQ-035 With nrst=0 at a rising edge: state=IDLE, busy=0, adc_ready=0, core_clr=0, core_en=0, core_last=0, core_sample=0, frame_done=0, sample_cnt=0.
REQ-036 Reset mid-frame discards the frame; no output pulses in the cycle after reset.

Structure
REQ-037 The state enum and SW default belong in a shared goertzel_pkg for reuse by the core and top level.
REQ-038 Single module; the sample counter is inline, with no sub-module.

Verification (N=4, SW=8, ADC model with adjustable valid gaps)
REQ-039 Reset, start pulse, adc_valid constant, samples 10,20,30,40 -> core_clr one cycle, core_en four cycles with core_sample 10,20,30,40, core_last only with 40, adc_ready low after the 4th transfer.
REQ-040 adc_valid toggling 1,0,1,0 -> core_en follows with 1-cycle lag, exactly 4 core_en pulses, sample_cnt 0->3.
REQ-041 Frame complete, core_done after 7 cycles -> frame_done pulse 1 cycle later, busy=0 the cycle after.
REQ-042 abort after the 2nd transfer -> IDLE next cycle, no core_last or frame_done; a later start restarts with core_clr and sample_cnt=0.
REQ-043 start during ACQ and spurious core_done in IDLE -> no state change; nrst=0 mid-ACQ -> all outputs at reset values.

Source files
------------

// File: rtl/goertzel_pkg.sv
// Shared definitions for the Goertzel sequencer and core: default sample
// width and the sequencer state encoding.
package goertzel_pkg;

  // Default ADC sample width used by the sequencer and the core.
  localparam int GZ_SW_DEFAULT = 8;

  // Sequencer state encoding.
  typedef logic [2:0] gz_state_t;

  localparam gz_state_t ST_IDLE      = 3'd0;
  localparam gz_state_t ST_CLEAR     = 3'd1;
  localparam gz_state_t ST_ACQ       = 3'd2;
  localparam gz_state_t ST_WAIT_CORE = 3'd3;
  localparam gz_state_t ST_DONE      = 3'd4;

endpackage

// File: rtl/goertzel_seq.sv
// Goertzel frame sequencer: clears the core, streams exactly N ADC samples
// into it with one cycle of latency, waits for the core's result and
// signals frame completion. Abort returns to IDLE from any state.
module goertzel_seq
  import goertzel_pkg::*;
#(
  parameter  int N  = 205,
  parameter  int SW = GZ_SW_DEFAULT,
  localparam int CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          adc_ready,
  input  logic          adc_valid,
  input  logic [SW-1:0] adc_sample,
  output logic          core_clr,
  output logic          core_en,
  output logic [SW-1:0] core_sample,
  output logic          core_last,
  input  logic          core_done,
  output logic          frame_done,
  output logic [CW-1:0] sample_cnt
);

  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  gz_state_t     r_state;
  gz_state_t     w_next;
  logic          r_core_en;
  logic          r_core_last;
  logic [SW-1:0] r_core_sample;
  logic [CW-1:0] r_cnt;

  logic          w_xfer;
  logic          w_last_xfer;
  logic          w_accept;

  // Status outputs decode directly from the registered state, so they are
  // glitch-free with respect to the inputs.
  assign busy       = (r_state != ST_IDLE);
  assign adc_ready  = (r_state == ST_ACQ);
  assign core_clr   = (r_state == ST_CLEAR);
  assign frame_done = (r_state == ST_DONE);

  assign core_en     = r_core_en;
  assign core_last   = r_core_last;
  assign core_sample = r_core_sample;
  assign sample_cnt  = r_cnt;

  assign w_xfer      = adc_valid && adc_ready;
  assign w_last_xfer = (r_cnt == LAST_IDX);
  // A transfer in the abort cycle still happens on the bus, but must not
  // reach the core.
  assign w_accept    = w_xfer && !abort;

  // Next-state selection; abort has priority over every other event.
  always_comb begin
    // NOTE: default assignment first so every path drives w_next and no
    // latch is inferred.
    w_next = r_state;
    case (r_state)
      ST_IDLE:      if (start && !abort) w_next = ST_CLEAR;
      ST_CLEAR:     w_next = abort ? ST_IDLE : ST_ACQ;
      ST_ACQ: begin
        if (abort)                         w_next = ST_IDLE;
        else if (w_xfer && w_last_xfer)    w_next = ST_WAIT_CORE;
      end
      ST_WAIT_CORE: begin
        if (abort)          w_next = ST_IDLE;
        else if (core_done) w_next = ST_DONE;
      end
      ST_DONE:      w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!nrst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Sample pipeline to the core and the in-frame sample counter.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_core_en     <= 1'b0;
      r_core_last   <= 1'b0;
      r_core_sample <= '0;
      r_cnt         <= '0;
    end else begin
      r_core_en   <= w_accept;
      r_core_last <= w_accept && w_last_xfer;
      if (w_accept) r_core_sample <= adc_sample;
      // The counter saturates at N-1: the transfer at N-1 is the frame's last.
      if (r_state == ST_CLEAR)            r_cnt <= '0;
      else if (w_xfer && !w_last_xfer)    r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
